// File: rtl/coin_vend_fsm_if.sv
// Coin acceptor / vend controller signal bundle.
// master drives coins and cancel; slave is the vend controller.
interface coin_vend_fsm_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic [1:0]          coins;
    logic                cancel;
    logic                coffee;
    logic                change;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coins,
        output cancel,
        input  coffee,
        input  change,
        input  credit,
        input  busy
    );

    modport slave (
        input  coins,
        input  cancel,
        output coffee,
        output change,
        output credit,
        output busy
    );
endinterface

// File: rtl/coin_vend_fsm.sv
// Moore coin-accumulating vend controller with configurable price.
// It returns any surplus, and any refunded credit, one 5-cent unit per cycle.
module coin_vend_fsm #(
    parameter int unsigned PRICE    = 3,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic clk,
    input  logic reset,
    coin_vend_fsm_if.slave bus
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_VEND   = 3'd2;
    localparam logic [2:0] ST_CHANGE = 3'd3;

    logic [2:0]          state_q;
    logic [2:0]          state_nx;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_nx;
    logic [2:0]          coin_units;
    logic [SUM_W-1:0]    sum;
    logic                coffee_q;
    logic                change_q;
    logic                busy_q;

    // Coin code to 5-cent units
    always_comb begin
        coin_units = 3'd0;
        case (bus.coins)
            2'b01:   coin_units = 3'd2;
            2'b10:   coin_units = 3'd1;
            2'b11:   coin_units = 3'd5;
            default: coin_units = 3'd0;
        endcase
    end

    assign sum = SUM_W'(credit_q) + SUM_W'(coin_units);

    // Next-state and next-credit
    always_comb begin
        state_nx  = ST_IDLE;
        credit_nx = '0;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (bus.cancel) begin
                    // A coin arriving with cancel joins the refund
                    if (sum != '0) begin
                        state_nx  = ST_CHANGE;
                        credit_nx = CREDIT_W'(sum);
                    end
                end else if (sum >= SUM_W'(PRICE)) begin
                    state_nx  = ST_VEND;
                    credit_nx = CREDIT_W'(sum - SUM_W'(PRICE));
                end else begin
                    credit_nx = CREDIT_W'(sum);
                    state_nx  = (sum != '0) ? ST_ACCUM : ST_IDLE;
                end
            end
            ST_VEND: begin
                credit_nx = credit_q;
                state_nx  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (credit_q > CREDIT_W'(1)) begin
                    state_nx  = ST_CHANGE;
                    credit_nx = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                credit_nx = '0;
            end
        endcase
    end

    // State, credit and decoded Moore outputs registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            coffee_q <= 1'b0;
            change_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            credit_q <= credit_nx;
            coffee_q <= (state_nx == ST_VEND);
            change_q <= (state_nx == ST_CHANGE);
            busy_q   <= (state_nx == ST_VEND) || (state_nx == ST_CHANGE);
        end
    end

    assign bus.coffee = coffee_q;
    assign bus.change = change_q;
    assign bus.busy   = busy_q;
    assign bus.credit = credit_q;
endmodule

// File: tb/tb_coin_vend_fsm.sv
// Directed self-checking bench for coin_vend_fsm at PRICE=3, CREDIT_W=4.
module tb_coin_vend_fsm;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    coin_vend_fsm_if #(.CREDIT_W(4)) bus ();

    coin_vend_fsm #(.PRICE(3), .CREDIT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.coins = 2'b11;
        bus.cancel = 1'b0;
        tick();
        tick();
        checks++; if (bus.credit !== 4'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", bus.credit); end
        checks++; if (bus.coffee !== 1'b0) begin failures++; $display("FAIL reset_coffee got=%b exp=0", bus.coffee); end
        checks++; if (bus.change !== 1'b0) begin failures++; $display("FAIL reset_change got=%b exp=0", bus.change); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        bus.coins = 2'b00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_exact_price;
        bus.coins = 2'b10;
        tick();
        checks++; if (bus.credit !== 4'd1 || bus.busy !== 1'b0) begin failures++; $display("FAIL exact_c1 credit=%0d busy=%b exp=1/0", bus.credit, bus.busy); end
        tick();
        checks++; if (bus.credit !== 4'd2 || bus.coffee !== 1'b0) begin failures++; $display("FAIL exact_c2 credit=%0d coffee=%b exp=2/0", bus.credit, bus.coffee); end
        tick();
        checks++; if (bus.coffee !== 1'b1 || bus.credit !== 4'd0 || bus.change !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL exact_vend coffee=%b credit=%0d change=%b busy=%b exp=1/0/0/1", bus.coffee, bus.credit, bus.change, bus.busy); end
        bus.coins = 2'b00;
        tick();
        checks++; if (bus.coffee !== 1'b0 || bus.busy !== 1'b0 || bus.change !== 1'b0 || bus.credit !== 4'd0) begin
            failures++; $display("FAIL exact_idle coffee=%b busy=%b change=%b credit=%0d exp=0/0/0/0", bus.coffee, bus.busy, bus.change, bus.credit); end
    endtask

    task automatic test_quarter_change;
        bus.coins = 2'b11;
        tick();
        bus.coins = 2'b00;
        checks++; if (bus.coffee !== 1'b1 || bus.credit !== 4'd2) begin failures++; $display("FAIL q_vend coffee=%b credit=%0d exp=1/2", bus.coffee, bus.credit); end
        tick();
        checks++; if (bus.change !== 1'b1 || bus.coffee !== 1'b0 || bus.credit !== 4'd2 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL q_chg1 change=%b coffee=%b credit=%0d busy=%b exp=1/0/2/1", bus.change, bus.coffee, bus.credit, bus.busy); end
        tick();
        checks++; if (bus.change !== 1'b1 || bus.credit !== 4'd1) begin failures++; $display("FAIL q_chg2 change=%b credit=%0d exp=1/1", bus.change, bus.credit); end
        tick();
        checks++; if (bus.change !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 4'd0) begin
            failures++; $display("FAIL q_done change=%b busy=%b credit=%0d exp=0/0/0", bus.change, bus.busy, bus.credit); end
        bus.coins = 2'b10;
        tick();
        bus.coins = 2'b00;
        checks++; if (bus.credit !== 4'd1) begin failures++; $display("FAIL q_next_coin credit=%0d exp=1", bus.credit); end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
        checks++; if (bus.credit !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL q_cleanup credit=%0d busy=%b exp=0/0", bus.credit, bus.busy); end
    endtask

    task automatic test_cancel_refund;
        int n_chg;
        int n_cof;
        logic any_out;
        bus.coins = 2'b01;
        tick();
        bus.coins = 2'b00;
        checks++; if (bus.credit !== 4'd2) begin failures++; $display("FAIL cancel_credit got=%0d exp=2", bus.credit); end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        checks++; if (bus.change !== 1'b1 || bus.credit !== 4'd2 || bus.coffee !== 1'b0) begin
            failures++; $display("FAIL cancel_first change=%b credit=%0d coffee=%b exp=1/2/0", bus.change, bus.credit, bus.coffee); end
        n_chg = 0;
        n_cof = 0;
        for (int i = 0; i < 6; i++) begin
            n_chg += int'(bus.change);
            n_cof += int'(bus.coffee);
            tick();
        end
        checks++; if (n_chg != 2 || n_cof != 0) begin failures++; $display("FAIL cancel_pulses change=%0d coffee=%0d exp=2/0", n_chg, n_cof); end
        checks++; if (bus.credit !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_end credit=%0d busy=%b exp=0/0", bus.credit, bus.busy); end
        bus.cancel = 1'b1;
        any_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_out = any_out | bus.change | bus.coffee | bus.busy | (bus.credit != 4'd0);
        end
        bus.cancel = 1'b0;
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL cancel_idle activity=%b exp=0", any_out); end
    endtask

    task automatic test_coin_during_vend;
        int n_chg;
        int n_cof;
        bus.coins = 2'b11;
        tick();
        n_cof = int'(bus.coffee);
        bus.coins = 2'b01;
        tick();
        bus.coins = 2'b00;
        n_chg = 0;
        for (int i = 0; i < 6; i++) begin
            n_chg += int'(bus.change);
            n_cof += int'(bus.coffee);
            tick();
        end
        checks++; if (n_chg != 2 || n_cof != 1) begin failures++; $display("FAIL busy_coin change=%0d coffee=%0d exp=2/1", n_chg, n_cof); end
        checks++; if (bus.credit !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL busy_coin_end credit=%0d busy=%b exp=0/0", bus.credit, bus.busy); end
    endtask

    task automatic test_coin_cancel_same;
        int n_chg;
        int n_cof;
        bus.coins = 2'b10;
        tick();
        checks++; if (bus.credit !== 4'd1) begin failures++; $display("FAIL cc_credit got=%0d exp=1", bus.credit); end
        bus.cancel = 1'b1;
        tick();
        bus.coins = 2'b00;
        bus.cancel = 1'b0;
        checks++; if (bus.change !== 1'b1 || bus.credit !== 4'd2) begin failures++; $display("FAIL cc_first change=%b credit=%0d exp=1/2", bus.change, bus.credit); end
        n_chg = 0;
        n_cof = 0;
        for (int i = 0; i < 6; i++) begin
            n_chg += int'(bus.change);
            n_cof += int'(bus.coffee);
            tick();
        end
        checks++; if (n_chg != 2 || n_cof != 0) begin failures++; $display("FAIL cc_pulses change=%0d coffee=%0d exp=2/0", n_chg, n_cof); end
    endtask

    task automatic test_reset_mid_change;
        bus.coins = 2'b11;
        tick();
        bus.coins = 2'b00;
        tick();
        checks++; if (bus.change !== 1'b1) begin failures++; $display("FAIL rm_in_change change=%b exp=1", bus.change); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.change !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 4'd0 || bus.coffee !== 1'b0) begin
            failures++; $display("FAIL rm_reset change=%b busy=%b credit=%0d coffee=%b exp=0/0/0/0", bus.change, bus.busy, bus.credit, bus.coffee); end
        bus.coins = 2'b10;
        tick();
        bus.coins = 2'b01;
        tick();
        bus.coins = 2'b00;
        checks++; if (bus.coffee !== 1'b1 || bus.credit !== 4'd0) begin failures++; $display("FAIL rm_revend coffee=%b credit=%0d exp=1/0", bus.coffee, bus.credit); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.change !== 1'b0 || bus.coffee !== 1'b0) begin
            failures++; $display("FAIL rm_idle busy=%b change=%b coffee=%b exp=0/0/0", bus.busy, bus.change, bus.coffee); end
    endtask

    task automatic test_back_to_back;
        bus.coins = 2'b01;
        tick();
        bus.coins = 2'b10;
        tick();
        checks++; if (bus.coffee !== 1'b1 || bus.credit !== 4'd0) begin failures++; $display("FAIL b2b_vend1 coffee=%b credit=%0d exp=1/0", bus.coffee, bus.credit); end
        bus.coins = 2'b01;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.credit !== 4'd0 || bus.coffee !== 1'b0) begin
            failures++; $display("FAIL b2b_lost busy=%b credit=%0d coffee=%b exp=0/0/0", bus.busy, bus.credit, bus.coffee); end
        tick();
        checks++; if (bus.credit !== 4'd2) begin failures++; $display("FAIL b2b_accum credit=%0d exp=2", bus.credit); end
        bus.coins = 2'b10;
        tick();
        bus.coins = 2'b00;
        checks++; if (bus.coffee !== 1'b1 || bus.credit !== 4'd0 || bus.change !== 1'b0) begin
            failures++; $display("FAIL b2b_vend2 coffee=%b credit=%0d change=%b exp=1/0/0", bus.coffee, bus.credit, bus.change); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.coins = 2'b00;
        bus.cancel = 1'b0;
        test_reset();
        test_exact_price();
        test_quarter_change();
        test_cancel_refund();
        test_coin_during_vend();
        test_coin_cancel_same();
        test_reset_mid_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
